// File: rtl/ex_muldiv_if.sv
// Execute-stage M-extension request/result bundle between the pipeline and ex_muldiv_unit.
// The master side issues ops and consumes results; the slave side is the engine.
interface ex_muldiv_if #(
  parameter int W = 32,
  parameter int R = 5
);
  logic         in_valid;
  logic [2:0]   in_funct3;
  logic [W-1:0] in_lhs;
  logic [W-1:0] in_rhs;
  logic [R-1:0] in_rd;
  logic         in_flush;
  logic         out_busy;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic [R-1:0] out_rd;

  modport master (
    output in_valid, in_funct3, in_lhs, in_rhs, in_rd, in_flush,
    input  out_busy, out_valid, out_result, out_rd
  );

  modport slave (
    input  in_valid, in_funct3, in_lhs, in_rhs, in_rd, in_flush,
    output out_busy, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine: one bit per cycle on operand magnitudes, sign fix on completion.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and zero-divisor divides skip the iteration.
module ex_muldiv_unit #(
  parameter int W = 32,
  parameter int R = 5
) (
  input  logic          clk1,
  input  logic          a_reset_n,
  ex_muldiv_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   cnt_reg;
  logic [2:0]     funct3_reg;
  logic [R-1:0]   rd_reg;
  logic [W-1:0]   a_reg;        // multiplicand, or dividend shifting out / quotient shifting in
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] acc_reg;      // {partial high, multiplier shifting out}
  logic [W:0]     rem_reg;
  logic           lhs_neg_reg, rhs_neg_reg, rhs_zero_reg;
  logic [W-1:0]   res_hold_reg;
  logic [R-1:0]   rd_hold_reg;

  logic           lhs_signed_in, rhs_signed_in, lhs_neg_in, rhs_neg_in;
  logic [W-1:0]   lhs_mag_in, rhs_mag_in;
  logic           accept, early_in, emit;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, result_done;

  always_comb begin
    lhs_signed_in = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b010) ||
                    (bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b110);
    rhs_signed_in = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b100) ||
                    (bus.in_funct3 == 3'b110);
    lhs_neg_in    = lhs_signed_in && bus.in_lhs[W-1];
    rhs_neg_in    = rhs_signed_in && bus.in_rhs[W-1];
    lhs_mag_in    = lhs_neg_in ? -bus.in_lhs : bus.in_lhs;
    rhs_mag_in    = rhs_neg_in ? -bus.in_rhs : bus.in_rhs;
  end

  assign accept = (state_reg == IDLE) && bus.in_valid && !bus.in_flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_in = bus.in_funct3[2] ? (bus.in_rhs == '0)
                                     : ((bus.in_lhs == '0) || (bus.in_rhs == '0));
`else
  assign early_in = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = early_in ? DONE : CALC;
      CALC:    if (bus.in_flush) state_next = IDLE;
               else if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration step of each algorithm
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
    div_shift = {rem_reg[W-1:0], a_reg[W-1]};
    div_diff  = div_shift - {1'b0, b_reg};
  end

  // Divide-by-zero keeps the quotient all ones; remainder naturally equals raw lhs
  always_comb begin
    prod_fix = (lhs_neg_reg ^ rhs_neg_reg) ? -acc_reg : acc_reg;
    quo_fix  = ((lhs_neg_reg ^ rhs_neg_reg) && !rhs_zero_reg) ? -a_reg : a_reg;
    rem_fix  = lhs_neg_reg ? -rem_reg[W-1:0] : rem_reg[W-1:0];
    case (funct3_reg)
      3'b000:                 result_done = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: result_done = prod_fix[2*W-1:W];
      3'b100, 3'b101:         result_done = quo_fix;
      default:                result_done = rem_fix;
    endcase
  end

  always_ff @(posedge clk1 or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      funct3_reg   <= '0;
      rd_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      lhs_neg_reg  <= 1'b0;
      rhs_neg_reg  <= 1'b0;
      rhs_zero_reg <= 1'b0;
      res_hold_reg <= '0;
      rd_hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (accept) begin
          funct3_reg   <= bus.in_funct3;
          rd_reg       <= bus.in_rd;
          a_reg        <= lhs_mag_in;
          b_reg        <= rhs_mag_in;
          lhs_neg_reg  <= lhs_neg_in;
          rhs_neg_reg  <= rhs_neg_in;
          rhs_zero_reg <= (bus.in_rhs == '0);
          cnt_reg      <= W'(W - 1);
          acc_reg      <= {{W{1'b0}}, rhs_mag_in};
          rem_reg      <= '0;
          if (early_in) begin
            acc_reg <= '0;
            a_reg   <= '1;
            rem_reg <= {1'b0, lhs_mag_in};
          end
        end
        CALC: if (!bus.in_flush) begin
          cnt_reg <= cnt_reg - 1'b1;
          if (funct3_reg[2]) begin
            rem_reg <= div_diff[W] ? div_shift : div_diff;
            a_reg   <= {a_reg[W-2:0], ~div_diff[W]};
          end else begin
            acc_reg <= {mul_sum, acc_reg[W-1:1]};
          end
        end
        DONE: if (!bus.in_flush) begin
          res_hold_reg <= result_done;
          rd_hold_reg  <= rd_reg;
        end
        default: ;
      endcase
    end
  end

  // Result is shown live during DONE and held afterwards; a flush in DONE leaves the held value
  assign emit           = (state_reg == DONE) && !bus.in_flush;
  assign bus.out_valid  = emit;
  assign bus.out_result = emit ? result_done : res_hold_reg;
  assign bus.out_rd     = emit ? rd_reg : rd_hold_reg;
  assign bus.out_busy   = (state_reg == CALC) || accept;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: latency, results, flush and mid-op reset.
module tb_ex_muldiv_unit;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
  localparam int LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic clk1 = 1'b0;
  logic a_reset_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [31:0] prev_exp = '0;

  ex_muldiv_if #(.W(32), .R(5)) bus ();

  ex_muldiv_unit #(.W(32), .R(5)) dut (
    .clk1      (clk1),
    .a_reset_n (a_reset_n),
    .bus       (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f;
    bus.in_lhs    = a;
    bus.in_rhs    = b;
    bus.in_rd     = rd;
  endtask

  // Called just after the negedge of the accept cycle; counts cycles until out_valid
  task automatic wait_result(input string tag, input logic [31:0] exp, input logic [4:0] exp_rd,
                             input int exp_lat);
    int  n = 0;
    bit  seen = 0;
    bit  busy_ok = 1;
    while (!seen && n < 100) begin
      @(posedge clk1); #1;
      bus.in_valid = 1'b0;
      @(negedge clk1);
      n++;
      if (bus.out_valid) seen = 1;
      else if (!bus.out_busy) busy_ok = 0;
    end
    check({tag, "_lat"}, 32'(seen ? n : -1), 32'(exp_lat));
    check({tag, "_result"}, bus.out_result, exp);
    check({tag, "_rd"}, {27'd0, bus.out_rd}, {27'd0, exp_rd});
    check({tag, "_busy_calc"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, bus.out_busy}, 32'd0);
    @(negedge clk1);
    check({tag, "_pulse"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_hold"}, bus.out_result, exp);
    $display("op %s: result=0x%08h rd=%0d latency=%0d", tag, bus.out_result, bus.out_rd, n);
    prev_exp = exp;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat);
    @(posedge clk1); #1;
    drive_op(f, a, b, rd);
    @(negedge clk1);
    check({tag, "_accept_busy"}, {31'd0, bus.out_busy}, 32'd1);
    wait_result(tag, exp, rd, exp_lat);
  endtask

  initial begin
    bit saw_pulse;
    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_lhs = '0; bus.in_rhs = '0;
    bus.in_rd = '0; bus.in_flush = 1'b0;

    repeat (2) @(negedge clk1);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy", {31'd0, bus.out_busy}, 32'd0);
    check("reset_result", bus.out_result, 32'd0);
    check("reset_rd", {27'd0, bus.out_rd}, 32'd0);
    a_reset_n = 1'b1;

    run_op("mul_7_m3",      F_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT);
    run_op("mul_shift",     F_MUL,    32'h12345678, 32'h00000010, 5'd6,  32'h23456780, LAT);
    run_op("mulh_min",      F_MULH,   32'h80000000, 32'h80000000, 5'd7,  32'h40000000, LAT);
    run_op("mulhu_max",     F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, LAT);
    run_op("mulhsu",        F_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd9,  32'hFFFFFFFF, LAT);
    run_op("div_m7_2",      F_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, LAT);
    run_op("rem_m7_2",      F_REM,    32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, LAT);
    run_op("divu_16",       F_DIVU,   32'hFFFFFFFF, 32'h00000010, 5'd12, 32'h0FFFFFFF, LAT);
    run_op("remu_100_7",    F_REMU,   32'd100,      32'd7,        5'd13, 32'd2,        LAT);
    run_op("div_ovf",       F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, LAT);
    run_op("rem_ovf",       F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, LAT);
    run_op("div_by0",       F_DIV,    32'h12345678, 32'h00000000, 5'd16, 32'hFFFFFFFF, ZLAT);
    run_op("rem_by0",       F_REM,    32'h12345678, 32'h00000000, 5'd17, 32'h12345678, ZLAT);
    run_op("div_neg_by0",   F_DIV,    32'hFFFFFFF9, 32'h00000000, 5'd18, 32'hFFFFFFFF, ZLAT);
    run_op("rem_neg_by0",   F_REM,    32'hFFFFFFF9, 32'h00000000, 5'd19, 32'hFFFFFFF9, ZLAT);

    // Flush in cycle 10 of a DIVU, then a back-to-back MUL in cycle 11
    saw_pulse = 0;
    @(posedge clk1); #1;
    drive_op(F_DIVU, 32'd100, 32'd7, 5'd20);
    @(negedge clk1);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk1); #1;
      bus.in_valid = 1'b0;
      if (c == 10) bus.in_flush = 1'b1;
      @(negedge clk1);
      if (bus.out_valid) saw_pulse = 1;
    end
    @(posedge clk1); #1;
    bus.in_flush = 1'b0;
    drive_op(F_MUL, 32'd3, 32'd5, 5'd2);
    @(negedge clk1);
    check("flush_no_pulse", {31'd0, saw_pulse | bus.out_valid}, 32'd0);
    check("flush_result_kept", bus.out_result, prev_exp);
    check("flush_next_accept_busy", {31'd0, bus.out_busy}, 32'd1);
    wait_result("after_flush_mul", 32'd15, 5'd2, LAT);

    // Reset dropped in cycle 15 of a MUL
    @(posedge clk1); #1;
    drive_op(F_MUL, 32'h00001234, 32'h00000010, 5'd21);
    @(negedge clk1);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk1); #1;
      bus.in_valid = 1'b0;
      if (c == 15) a_reset_n = 1'b0;
      @(negedge clk1);
    end
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.out_busy}, 32'd0);
    check("rst_result", bus.out_result, 32'd0);
    check("rst_rd", {27'd0, bus.out_rd}, 32'd0);
    repeat (2) @(negedge clk1);
    a_reset_n = 1'b1;
    run_op("mul_3_4_after_rst", F_MUL, 32'd3, 32'd4, 5'd3, 32'h0000000C, LAT);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
